// File: rtl/decoder_nto2n_seq.sv
// Registered N-to-2^N one-hot decoder with direct,
// scan-up, scan-down and hold modes plus wrap pulse.
module decoder_nto2n_seq #(
  parameter int N       = 3,
  parameter int OUT_W   = 2**N,
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [1:0]         mode,
  input  logic [N-1:0]       in,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DWELL_W-1:0] dwell,
  output logic [OUT_W-1:0]   d,
  output logic               d_valid,
  output logic [N-1:0]       idx,
  output logic               wrap
);

  typedef enum logic [1:0] {
    M_DIRECT = 2'b00,
    M_UP     = 2'b01,
    M_DOWN   = 2'b10,
    M_HOLD   = 2'b11
  } mode_e;

  localparam logic [OUT_W-1:0] ONE = OUT_W'(1);
  localparam logic [N-1:0]     TOP = '1;
  localparam logic [N-1:0]     BOT = '0;

  mode_e               cur;
  mode_e               prev_mode;
  logic                prev_en;
  logic [DWELL_W-1:0]  cnt;
  logic [DWELL_W-1:0]  cnt_n;
  logic [N-1:0]        idx_n;
  logic                dv_n;
  logic                wrap_n;
  logic                chg;
  logic                step;
  logic [OUT_W-1:0]    d_n;

  assign cur      = mode_e'(mode);
  assign in_ready = en & (cur == M_DIRECT);
  assign chg      = (cur != prev_mode) | (en & ~prev_en);
  assign step     = (cnt >= dwell);

  // next-state: index, valid, dwell counter and wrap pulse
  always_comb begin
    idx_n  = idx;
    dv_n   = d_valid;
    cnt_n  = cnt;
    wrap_n = 1'b0;
    if (!en) begin
      dv_n  = 1'b0;
      cnt_n = '0;
    end else begin
      unique case (cur)
        M_DIRECT: begin
          if (chg) cnt_n = '0;
          if (in_valid && in_ready) begin
            idx_n = in;
            dv_n  = 1'b1;
          end
        end
        M_UP: begin
          dv_n = 1'b1;
          if (chg) begin
            cnt_n = '0;
          end else if (step) begin
            cnt_n  = '0;
            idx_n  = idx + 1'b1;
            wrap_n = (idx == TOP);
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        M_DOWN: begin
          dv_n = 1'b1;
          if (chg) begin
            cnt_n = '0;
          end else if (step) begin
            cnt_n  = '0;
            idx_n  = idx - 1'b1;
            wrap_n = (idx == BOT);
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        M_HOLD: begin
          if (chg) cnt_n = '0;
        end
        default: ;
      endcase
    end
    d_n = dv_n ? (ONE << idx_n) : '0;
  end

  // state registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      d         <= '0;
      d_valid   <= 1'b0;
      idx       <= '0;
      wrap      <= 1'b0;
      cnt       <= '0;
      prev_mode <= M_DIRECT;
      prev_en   <= 1'b0;
    end else begin
      d         <= d_n;
      d_valid   <= dv_n;
      idx       <= idx_n;
      wrap      <= wrap_n;
      cnt       <= cnt_n;
      prev_mode <= cur;
      prev_en   <= en;
    end
  end

endmodule

// File: tb/tb_decoder_nto2n_seq.sv
// Directed self-checking bench for decoder_nto2n_seq
// (N=3, DWELL_W=8), checks sampled 1ns after clk rise.
module tb_decoder_nto2n_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [1:0] mode;
  logic [2:0] in;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] dwell;
  logic [7:0] d;
  logic       d_valid;
  logic [2:0] idx;
  logic       wrap;

  int checks   = 0;
  int failures = 0;

  decoder_nto2n_seq #(.N(3), .DWELL_W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .mode     (mode),
    .in       (in),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .dwell    (dwell),
    .d        (d),
    .d_valid  (d_valid),
    .idx      (idx),
    .wrap     (wrap)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag,
                         input int ei,
                         input logic ev,
                         input logic ew);
    logic [7:0] ed;
    ed = ev ? (8'd1 << ei) : 8'd0;
    chk({tag, ".idx"}, 32'(idx), 32'(ei));
    chk({tag, ".d"}, 32'(d), 32'(ed));
    chk({tag, ".dv"}, 32'(d_valid), 32'(ev));
    chk({tag, ".wrap"}, 32'(wrap), 32'(ew));
  endtask

  initial begin
    int up_i[8]  = '{6, 6, 6, 7, 7, 7, 0, 0};
    bit up_w[8]  = '{0, 0, 0, 0, 0, 0, 1, 0};
    int dn_i[4]  = '{1, 0, 7, 6};
    bit dn_w[4]  = '{0, 0, 1, 0};

    rst_n = 1'b0; en = 1'b1; mode = 2'b00;
    in = 3'd0; in_valid = 1'b0; dwell = 8'd0;
    tick();
    tick();
    chk_out("reset", 0, 1'b0, 1'b0);
    chk("reset.ready", 32'(in_ready), 32'd1);

    rst_n = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in = 3'(i);
      tick();
      chk_out("direct", i, 1'b1, 1'b0);
    end

    in_valid = 1'b0; in = 3'd2;
    tick();
    tick();
    chk_out("direct_hold", 7, 1'b1, 1'b0);

    in_valid = 1'b1; in = 3'd6;
    tick();
    chk_out("direct6", 6, 1'b1, 1'b0);

    in_valid = 1'b0; mode = 2'b01; dwell = 8'd2;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk_out("scan_up", up_i[i], 1'b1, up_w[i]);
    end

    mode = 2'b00; in_valid = 1'b1; in = 3'd1;
    tick();
    chk_out("direct1", 1, 1'b1, 1'b0);

    mode = 2'b10; dwell = 8'd0; in = 3'd3;
    #1;
    chk("down.ready", 32'(in_ready), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_out("scan_dn", dn_i[i], 1'b1, dn_w[i]);
      chk("scan_dn.ready", 32'(in_ready), 32'd0);
    end

    in_valid = 1'b0; mode = 2'b01; dwell = 8'd1;
    tick();
    tick();
    chk_out("up_d1a", 6, 1'b1, 1'b0);
    tick();
    chk_out("up_d1b", 7, 1'b1, 1'b0);

    mode = 2'b11;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_out("hold", 7, 1'b1, 1'b0);
    end

    mode = 2'b01;
    tick();
    tick();
    chk_out("resume_wait", 7, 1'b1, 1'b0);
    tick();
    chk_out("resume_step", 0, 1'b1, 1'b1);

    en = 1'b0;
    tick();
    chk_out("en_off", 0, 1'b0, 1'b0);
    mode = 2'b00; in_valid = 1'b1; in = 3'd5;
    #1;
    chk("en_off.ready", 32'(in_ready), 32'd0);
    tick();
    chk_out("en_off_ign", 0, 1'b0, 1'b0);

    en = 1'b1; mode = 2'b01; dwell = 8'd0;
    in_valid = 1'b0;
    tick();
    chk_out("en_rise", 0, 1'b1, 1'b0);
    tick();
    chk_out("en_rise_step", 1, 1'b1, 1'b0);

    mode = 2'b00; in_valid = 1'b1; in = 3'd5;
    tick();
    mode = 2'b01; dwell = 8'd3; in_valid = 1'b0;
    tick();
    tick();
    chk_out("pre_rst", 5, 1'b1, 1'b0);
    rst_n = 1'b0;
    tick();
    chk_out("mid_rst", 0, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick();
    chk_out("post_rst", 0, 1'b1, 1'b0);
    tick();
    tick();
    tick();
    chk_out("post_rst_wait", 0, 1'b1, 1'b0);
    tick();
    chk_out("post_rst_step", 1, 1'b1, 1'b0);

    tick();
    tick();
    chk_out("dwell_cnt2", 1, 1'b1, 1'b0);
    dwell = 8'd1;
    tick();
    chk_out("dwell_shrink", 2, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
